// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the program loader.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              start_i;
   logic              byte_valid_i;
   logic [7:0]        byte_data_i;
   logic              byte_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [7:0]        mem_wdata_o;
   logic              busy_o;
   logic              done_o;
   logic              error_o;
   logic              core_hold_o;

   // Loader side
   modport slave (
      input  start_i, byte_valid_i, byte_data_i,
      output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output busy_o, done_o, error_o, core_hold_o
   );

   // Stream source / memory / core side
   modport master (
      output start_i, byte_valid_i, byte_data_i,
      input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  busy_o, done_o, error_o, core_hold_o
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: parses [len32 LE][payload][xor csum] and writes
// the payload to byte addresses 0..len-1, holding the core until a good load completes.
module imem_loader #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   imem_loader_if.slave    bus
);
   localparam int unsigned LEN_W = 32;
   localparam int unsigned IDX_W = 2;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [IDX_W-1:0]  hdr_idx_q, hdr_idx_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              core_hold_q, core_hold_d;
   logic              accept_c;

   // start_i wins over a byte offered in the same cycle
   assign accept_c = busy_q & bus.byte_valid_i & ~bus.start_i;

   // Next-state, counters and registered output values
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      hdr_idx_d   = hdr_idx_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (bus.start_i) begin
         state_d   = S_LEN;
         len_d     = '0;
         hdr_idx_d = '0;
         cnt_d     = '0;
         csum_d    = '0;
      end else if (accept_c) begin
         unique case (state_q)
            S_LEN: begin
               // len is cleared on start, so OR-ing each byte into its lane assembles it
               len_d     = len_q | (LEN_W'(bus.byte_data_i) << {hdr_idx_q, 3'b000});
               hdr_idx_d = hdr_idx_q + IDX_W'(1);
               if (hdr_idx_q == IDX_W'(3)) begin
                  if (len_d == '0)                         state_d = S_CSUM;
                  else if (len_d > LEN_W'(MEM_BYTES))      state_d = S_ERR;
                  else                                     state_d = S_DATA;
               end
            end
            S_DATA: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ADDR_W'(cnt_q);
               mem_wdata_d = bus.byte_data_i;
               cnt_d       = cnt_q + LEN_W'(1);
               csum_d      = csum_q ^ bus.byte_data_i;
               if (cnt_d == len_q) state_d = S_CSUM;
            end
            S_CSUM: begin
               state_d = (bus.byte_data_i == csum_q) ? S_DONE : S_ERR;
            end
            default: ;
         endcase
      end

      busy_d      = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      done_d      = (state_d == S_DONE);
      error_d     = (state_d == S_ERR);
      core_hold_d = (state_d != S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         hdr_idx_q   <= '0;
         cnt_q       <= '0;
         csum_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         core_hold_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         hdr_idx_q   <= hdr_idx_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         core_hold_q <= core_hold_d;
      end
   end

   assign bus.byte_ready_o = busy_q & ~bus.start_i;
   assign bus.mem_we_o     = mem_we_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_wdata_o  = mem_wdata_q;
   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.error_o      = error_q;
   assign bus.core_hold_o  = core_hold_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-position model checked every cycle plus literal checks.
module tb_imem_loader;
   localparam int unsigned MEM_BYTES = 1024;
   localparam int unsigned ADDR_W    = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus();

   imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: position in the frame decides the role of each accepted byte
   logic        m_loading;
   int          m_count;
   logic [31:0] m_len;
   logic [7:0]  m_csum;
   logic        e_we, e_done, e_err, e_hold;
   logic [31:0] e_addr;
   logic [7:0]  e_wdata;

   function automatic logic [31:0] full_len(input logic [31:0] l, input logic [7:0] b);
      return l | {b, 24'h0};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_loading <= 1'b0; m_count <= 0; m_len <= '0; m_csum <= '0;
         e_we <= 1'b0; e_addr <= '0; e_wdata <= '0;
         e_done <= 1'b0; e_err <= 1'b0; e_hold <= 1'b1;
      end else begin
         e_we <= 1'b0;
         if (bus.start_i) begin
            m_loading <= 1'b1; m_count <= 0; m_len <= '0; m_csum <= '0;
            e_done <= 1'b0; e_err <= 1'b0; e_hold <= 1'b1;
         end else if (m_loading && bus.byte_valid_i) begin
            m_count <= m_count + 1;
            if (m_count < 4) begin
               m_len <= m_len | (32'(bus.byte_data_i) << (8 * m_count));
               if (m_count == 3 && full_len(m_len, bus.byte_data_i) > 32'(MEM_BYTES)) begin
                  m_loading <= 1'b0; e_err <= 1'b1;
               end
            end else if (32'(m_count - 4) < m_len) begin
               e_we <= 1'b1; e_addr <= 32'(m_count - 4); e_wdata <= bus.byte_data_i;
               m_csum <= m_csum ^ bus.byte_data_i;
            end else begin
               m_loading <= 1'b0;
               if (bus.byte_data_i == m_csum) begin e_done <= 1'b1; e_hold <= 1'b0; end
               else e_err <= 1'b1;
            end
         end
      end
   end

   // Observed writes, used by the literal checks
   logic [7:0]  mem_seen [MEM_BYTES];
   int          wr_count = 0;
   logic [31:0] last_addr = '0;

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("we",    32'(bus.mem_we_o),     32'(e_we));
      chk("addr",  32'(bus.mem_addr_o),   e_addr);
      chk("wdata", 32'(bus.mem_wdata_o),  32'(e_wdata));
      chk("ready", 32'(bus.byte_ready_o), 32'(m_loading & ~bus.start_i));
      chk("busy",  32'(bus.busy_o),       32'(m_loading));
      chk("done",  32'(bus.done_o),       32'(e_done));
      chk("error", 32'(bus.error_o),      32'(e_err));
      chk("hold",  32'(bus.core_hold_o),  32'(e_hold));
      if (bus.mem_we_o === 1'b1) begin
         mem_seen[bus.mem_addr_o[9:0]] <= bus.mem_wdata_o;
         wr_count  <= wr_count + 1;
         last_addr <= 32'(bus.mem_addr_o);
      end
   end

   task automatic cyc(input logic v, input logic [7:0] d, input logic s);
      bus.byte_valid_i = v;
      bus.byte_data_i  = d;
      bus.start_i      = s;
      @(posedge clk); #1;
      bus.byte_valid_i = 1'b0;
      bus.start_i      = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      cyc(1'b1, d, 1'b0);
   endtask

   task automatic start_pulse();
      cyc(1'b0, 8'h00, 1'b1);
   endtask

   task automatic send_hdr(input logic [31:0] len);
      send(len[7:0]); send(len[15:8]); send(len[23:16]); send(len[31:24]);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 8'h00, 1'b0);
   endtask

   task automatic chk_status(input string name, input logic d, input logic e, input logic h);
      chk({name, "_done"}, 32'(bus.done_o), 32'(d));
      chk({name, "_err"},  32'(bus.error_o), 32'(e));
      chk({name, "_hold"}, 32'(bus.core_hold_o), 32'(h));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w0;
      logic [7:0]  cs;
      bus.start_i = 1'b0; bus.byte_valid_i = 1'b0; bus.byte_data_i = 8'h00;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_we",    32'(bus.mem_we_o), 0);
      chk("rst_ready", 32'(bus.byte_ready_o), 0);
      chk("rst_busy",  32'(bus.busy_o), 0);
      chk_status("rst", 1'b0, 1'b0, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      chk("idle_ready", 32'(bus.byte_ready_o), 0);

      // Good load
      w0 = wr_count;
      start_pulse(); send_hdr(32'd4);
      send(8'h13); send(8'h05); send(8'h10); send(8'h00); send(8'h06);
      idle(2);
      chk("good_nwr", 32'(wr_count - w0), 4);
      chk("good_m0", 32'(mem_seen[0]), 32'h13);
      chk("good_m1", 32'(mem_seen[1]), 32'h05);
      chk("good_m2", 32'(mem_seen[2]), 32'h10);
      chk("good_m3", 32'(mem_seen[3]), 32'h00);
      chk_status("good", 1'b1, 1'b0, 1'b0);

      // Bad checksum
      w0 = wr_count;
      start_pulse(); send_hdr(32'd4);
      send(8'h13); send(8'h05); send(8'h10); send(8'h00); send(8'h07);
      idle(2);
      chk("bad_nwr", 32'(wr_count - w0), 4);
      chk("bad_last", last_addr, 3);
      chk_status("bad", 1'b0, 1'b1, 1'b1);

      // Oversize header: 1025
      w0 = wr_count;
      start_pulse(); send_hdr(32'd1025);
      chk_status("over", 1'b0, 1'b1, 1'b1);
      send(8'hAA); send(8'hBB); send(8'hCC);
      idle(1);
      chk("over_nwr", 32'(wr_count - w0), 0);
      chk("over_ready", 32'(bus.byte_ready_o), 0);

      // Maximum length: 1024
      w0 = wr_count;
      start_pulse(); send_hdr(32'd1024);
      for (int i = 0; i < 1024; i++) send(8'(i));
      send(8'h00);
      idle(2);
      chk("max_nwr", 32'(wr_count - w0), 1024);
      chk("max_last", last_addr, 1023);
      chk("max_m1023", 32'(mem_seen[1023]), 32'hFF);
      chk_status("max", 1'b1, 1'b0, 1'b0);

      // Zero length, good then bad checksum
      w0 = wr_count;
      start_pulse(); send_hdr(32'd0); send(8'h00);
      idle(1);
      chk("zero_nwr", 32'(wr_count - w0), 0);
      chk_status("zero", 1'b1, 1'b0, 1'b0);
      start_pulse(); send_hdr(32'd0); send(8'h01);
      idle(1);
      chk_status("zerobad", 1'b0, 1'b1, 1'b1);

      // Backpressure gaps
      w0 = wr_count;
      cs = 8'h00;
      start_pulse(); send_hdr(32'd6);
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 3)) cyc(1'b0, 8'hEE, 1'b0);
         send(8'h20 + 8'(i));
         cs = cs ^ (8'h20 + 8'(i));
      end
      idle(2);
      send(cs);
      idle(1);
      chk("bp_nwr", 32'(wr_count - w0), 6);
      chk("bp_m5", 32'(mem_seen[5]), 32'h25);
      chk_status("bp", 1'b1, 1'b0, 1'b0);

      // Restart mid-payload with a byte offered alongside start
      w0 = wr_count;
      start_pulse(); send_hdr(32'd4); send(8'h51); send(8'h52);
      cyc(1'b1, 8'h99, 1'b1);
      send_hdr(32'd2); send(8'h31); send(8'h32); send(8'h03);
      idle(2);
      chk("rs_nwr", 32'(wr_count - w0), 4);
      chk("rs_m0", 32'(mem_seen[0]), 32'h31);
      chk("rs_m1", 32'(mem_seen[1]), 32'h32);
      chk("rs_last", last_addr, 1);
      chk_status("rs", 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-payload
      start_pulse(); send_hdr(32'd8); send(8'h41); send(8'h42);
      bus.byte_valid_i = 1'b1; bus.byte_data_i = 8'h43;
      #2 rst_n = 1'b0;
      #1;
      bus.byte_valid_i = 1'b0;
      chk("ar_we",    32'(bus.mem_we_o), 0);
      chk("ar_addr",  32'(bus.mem_addr_o), 0);
      chk("ar_wdata", 32'(bus.mem_wdata_o), 0);
      chk("ar_ready", 32'(bus.byte_ready_o), 0);
      chk("ar_busy",  32'(bus.busy_o), 0);
      chk_status("ar", 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(3);
      chk("ar_idle_ready", 32'(bus.byte_ready_o), 0);
      chk("ar_idle_busy",  32'(bus.busy_o), 0);
      w0 = wr_count;
      start_pulse(); send_hdr(32'd1); send(8'h55); send(8'h55);
      idle(2);
      chk("ar2_nwr", 32'(wr_count - w0), 1);
      chk("ar2_m0", 32'(mem_seen[0]), 32'h55);
      chk_status("ar2", 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that acts as the write side of the processor's byte-addressed instruction memory. It accepts a framed byte stream over a valid/ready handshake (typically from a UART receiver) and parses a 4-byte little-endian length header, the payload and a 1-byte XOR checksum. Each payload byte is written into instruction memory at consecutive byte addresses starting at 0. The core is held stalled until a load completes with a correct checksum.

## Interface
Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; the largest legal payload length.
- ADDR_W, 32, width of the memory write address.

Ports:
- clk_i  input  1  single clock; all logic on its rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  begins a new load; one-cycle pulse.
- byte_valid_i  input  1  stream byte valid.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- mem_we_o  output  1  instruction memory byte write enable.
- mem_addr_o  output  ADDR_W  byte address of the write.
- mem_wdata_o  output  8  byte to write.
- busy_o  output  1  high in states LEN, DATA and CSUM.
- done_o  output  1  last load completed with a good checksum.
- error_o  output  1  last load failed.
- core_hold_o  output  1  keeps the processor stalled.

## Operation
- A byte is accepted on a rising edge when byte_valid_i and byte_ready_o are both high.
- byte_ready_o = 1 only in LEN, DATA or CSUM, and only when start_i = 0. start_i has priority, so a byte presented in the same cycle as start_i is not consumed.
- States and transitions:
  - IDLE. The state after reset. On start_i, go to LEN.
  - LEN. Accepted byte k (k = 0..3) is written into len[8k+7:8k]. After the 4th byte:
    - len == 0: go to CSUM.
    - len > MEM_BYTES (32-bit unsigned compare): go to ERR.
    - otherwise: go to DATA.
  - DATA. Each accepted byte is written to address cnt, then cnt increments and csum ^= byte. When the accepted byte is byte number len, go to CSUM.
  - CSUM. Accept one byte. If it equals csum, go to DONE; otherwise go to ERR. csum covers payload bytes only (not the header or the checksum byte).
  - DONE. done_o = 1, core_hold_o = 0. On start_i, go to LEN.
  - ERR. error_o = 1, core_hold_o = 1. On start_i, go to LEN.
- Clearing on start_i, from any state other than IDLE:
  - len, cnt and csum are cleared; done_o and error_o are cleared; core_hold_o is set to 1.
  - start_i during LEN, DATA or CSUM aborts the current load and restarts in LEN. Bytes already written stay in memory.
- Lengths and addressing:
  - len == MEM_BYTES is legal and writes addresses 0..MEM_BYTES-1.
  - cnt never exceeds len, so addresses never wrap.
- Reset (asynchronous, at any time, including mid-load):
  - State goes to IDLE and all counters clear.
  - Memory contents are not affected.

## Timing
Reset values:
- byte_ready_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0
- busy_o = 0, done_o = 0, error_o = 0
- core_hold_o = 1

Write timing:
- mem_we_o, mem_addr_o and mem_wdata_o are registered.
- A payload byte accepted at edge N produces mem_we_o = 1 for exactly the cycle after edge N, with the matching address and data.
- mem_we_o is 0 in every other cycle. Address and data hold their last values when mem_we_o = 0.

Status timing:
- State, done_o, error_o and core_hold_o update at the edge that accepts the terminating byte. For example, done_o is first observed high in the cycle after the checksum byte is accepted.

Throughput:
- One byte per cycle sustained, with no bubbles between LEN, DATA and CSUM.
- Gaps in byte_valid_i stall progress without any loss of bytes or writes.

Overlap:
- The final payload write (mem_we_o high) occurs during the first CSUM cycle. This overlap is legal.

## Test plan
- Good load: after reset, start; stream 04 00 00 00, 13 05 10 00, 06 -> writes (0,13), (1,05), (2,10), (3,00), each as a single-cycle mem_we_o pulse; done_o = 1, core_hold_o = 0, error_o = 0.
- Bad checksum: same stream with a final byte of 07 -> the same 4 writes occur; error_o = 1, core_hold_o = 1, done_o = 0.
- Oversize: MEM_BYTES = 1024; stream 01 04 00 00 (len = 1025) -> ERR after the 4th byte; no mem_we_o pulses; byte_ready_o = 0 thereafter. Also send 00 04 00 00 (len = 1024) -> accepted, with the last write at address 1023.
- Zero length: stream 00 00 00 00, 00 -> no writes; done_o = 1. Repeat with a final byte of 01 -> error_o = 1.
- Backpressure and restart: random byte_valid_i gaps -> one write per accepted byte, in order. Pulse start_i together with byte_valid_i after 2 payload bytes -> that byte is not consumed; the next good frame writes from address 0 and ends with done_o = 1.
- Async reset mid-DATA: assert rst_ni low between clock edges -> all outputs take their reset values immediately; after release the block is in IDLE with byte_ready_o = 0 until start_i.
